// File: rtl/regfile_scoreboard.sv
// Register-file scoreboard: tracks pending writes per register, answers source
// busy queries with same-cycle writeback bypass, and drives a registered one-hot write enable.
module regfile_scoreboard #(
  parameter int unsigned ADDR_W      = 5,
  parameter bit          ZERO_REG_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_rd,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_rd,
  input  logic [ADDR_W-1:0]        src_a,
  input  logic [ADDR_W-1:0]        src_b,
  output logic                     busy_a,
  output logic                     busy_b,
  output logic                     issue_stall,
  output logic [(2**ADDR_W)-1:0]   we_onehot,
  output logic [(2**ADDR_W)-1:0]   pending,
  output logic [ADDR_W:0]          pending_count,
  output logic                     wb_err
);

  localparam int unsigned NUM_REGS = 2**ADDR_W;

  function automatic logic [NUM_REGS-1:0] decode(input logic [ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (addr == ADDR_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] r_we_onehot;
  logic [ADDR_W:0]     r_count;
  logic                r_wb_err;

  logic [NUM_REGS-1:0] w_zero_mask;
  logic [NUM_REGS-1:0] w_wb_hit;
  logic [NUM_REGS-1:0] w_wb_eff;
  logic [NUM_REGS-1:0] w_issue_set;
  logic [NUM_REGS-1:0] w_pending_nxt;
  logic                w_issue_stall;
  logic                w_issue_acc;
  logic                w_wb_clr;
  logic                w_wb_err;
  logic [ADDR_W:0]     w_count_nxt;

  // The zero register is folded into a mask so every hazard term excludes it uniformly.
  assign w_zero_mask = {ZERO_REG_EN, {(NUM_REGS-1){1'b0}}};

  always_comb begin
    w_wb_hit      = wb_valid ? decode(wb_rd) : '0;
    w_wb_eff      = w_wb_hit & ~w_zero_mask;
    w_issue_stall = issue_valid & r_pending[issue_rd] & ~w_wb_hit[issue_rd]
                    & ~w_zero_mask[issue_rd];
    w_issue_acc   = issue_valid & ~w_issue_stall & ~w_zero_mask[issue_rd];
    w_issue_set   = w_issue_acc ? decode(issue_rd) : '0;
    // Clear-then-set: a same-cycle writeback and issue to one register leaves it pending.
    w_pending_nxt = ((r_pending & ~w_wb_hit) | w_issue_set) & ~w_zero_mask;
    w_wb_clr      = |(w_wb_eff & r_pending);
    w_wb_err      = wb_valid & ~r_pending[wb_rd] & ~w_zero_mask[wb_rd];
    w_count_nxt   = r_count + (ADDR_W+1)'(w_issue_acc) - (ADDR_W+1)'(w_wb_clr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending   <= '0;
      r_we_onehot <= '0;
      r_count     <= '0;
      r_wb_err    <= 1'b0;
    end else begin
      r_pending   <= w_pending_nxt;
      r_we_onehot <= w_wb_eff;
      r_count     <= w_count_nxt;
      r_wb_err    <= w_wb_err;
    end
  end

  assign busy_a        = r_pending[src_a] & ~w_wb_hit[src_a] & ~w_zero_mask[src_a];
  assign busy_b        = r_pending[src_b] & ~w_wb_hit[src_b] & ~w_zero_mask[src_b];
  assign issue_stall   = w_issue_stall;
  assign we_onehot     = r_we_onehot;
  assign pending       = r_pending;
  assign pending_count = r_count;
  assign wb_err        = r_wb_err;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two instances (zero register tracked / not tracked)
// share stimulus and are checked against an array-based model of the pending set.
module tb_regfile_scoreboard;

  localparam int unsigned NR = 32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [4:0]  src_a;
  logic [4:0]  src_b;

  logic        busy_a_z, busy_b_z, stall_z, err_z;
  logic [31:0] we_z, pend_z;
  logic [5:0]  cnt_z;
  logic        busy_a_n, busy_b_n, stall_n, err_n;
  logic [31:0] we_n, pend_n;
  logic [5:0]  cnt_n;

  regfile_scoreboard #(.ADDR_W(5), .ZERO_REG_EN(1'b1)) dut_z (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .src_a(src_a), .src_b(src_b),
    .busy_a(busy_a_z), .busy_b(busy_b_z), .issue_stall(stall_z),
    .we_onehot(we_z), .pending(pend_z), .pending_count(cnt_z), .wb_err(err_z)
  );

  regfile_scoreboard #(.ADDR_W(5), .ZERO_REG_EN(1'b0)) dut_n (
    .clk(clk), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .src_a(src_a), .src_b(src_b),
    .busy_a(busy_a_n), .busy_b(busy_b_n), .issue_stall(stall_n),
    .we_onehot(we_n), .pending(pend_n), .pending_count(cnt_n), .wb_err(err_n)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model state, index 1 = zero register enabled, index 0 = disabled.
  bit          m_pend [2][NR];
  logic [31:0] m_we   [2];
  logic        m_err  [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit zr(input int z, input logic [4:0] r);
    return (z == 1) && (r == 5'd31);
  endfunction

  function automatic bit wbh(input logic [4:0] r);
    return wb_valid && (wb_rd == r);
  endfunction

  function automatic bit exp_busy(input int z, input logic [4:0] r);
    return m_pend[z][r] && !wbh(r) && !zr(z, r);
  endfunction

  function automatic bit exp_stall(input int z);
    return issue_valid && m_pend[z][issue_rd] && !wbh(issue_rd) && !zr(z, issue_rd);
  endfunction

  function automatic logic [31:0] pvec(input int z);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NR; i++) v[i] = m_pend[z][i];
    return v;
  endfunction

  function automatic int pcount(input int z);
    int c;
    c = 0;
    for (int i = 0; i < NR; i++) c += int'(m_pend[z][i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < NR; i++) m_pend[z][i] = 1'b0;
      m_we[z]  = '0;
      m_err[z] = 1'b0;
    end
  endtask

  task automatic model_update();
    bit acc;
    for (int z = 0; z < 2; z++) begin
      acc      = issue_valid && !exp_stall(z) && !zr(z, issue_rd);
      m_we[z]  = (wb_valid && !zr(z, wb_rd)) ? (32'd1 << wb_rd) : 32'd0;
      m_err[z] = wb_valid && !m_pend[z][wb_rd] && !zr(z, wb_rd);
      if (wb_valid && !zr(z, wb_rd)) m_pend[z][wb_rd] = 1'b0;
      if (acc) m_pend[z][issue_rd] = 1'b1;
    end
  endtask

  task automatic check_comb();
    chk("busy_a_z", 64'(busy_a_z), 64'(exp_busy(1, src_a)));
    chk("busy_b_z", 64'(busy_b_z), 64'(exp_busy(1, src_b)));
    chk("stall_z",  64'(stall_z),  64'(exp_stall(1)));
    chk("busy_a_n", 64'(busy_a_n), 64'(exp_busy(0, src_a)));
    chk("busy_b_n", 64'(busy_b_n), 64'(exp_busy(0, src_b)));
    chk("stall_n",  64'(stall_n),  64'(exp_stall(0)));
  endtask

  task automatic check_regs();
    chk("pending_z", 64'(pend_z), 64'(pvec(1)));
    chk("count_z",   64'(cnt_z),  64'(pcount(1)));
    chk("we_z",      64'(we_z),   64'(m_we[1]));
    chk("err_z",     64'(err_z),  64'(m_err[1]));
    chk("pending_n", 64'(pend_n), 64'(pvec(0)));
    chk("count_n",   64'(cnt_n),  64'(pcount(0)));
    chk("we_n",      64'(we_n),   64'(m_we[0]));
    chk("err_n",     64'(err_n),  64'(m_err[0]));
  endtask

  task automatic step(input bit iv, input logic [4:0] ird, input bit wv,
                      input logic [4:0] wrd, input logic [4:0] sa, input logic [4:0] sb);
    @(negedge clk);
    issue_valid = iv; issue_rd = ird; wb_valid = wv; wb_rd = wrd;
    src_a = sa; src_b = sb;
    #1;
    check_comb();
    model_update();
    @(posedge clk);
    #1;
    check_regs();
  endtask

  initial begin
    reset_n = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; wb_valid = 1'b0; wb_rd = '0;
    src_a = 5'd0; src_b = 5'd30;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_regs();
    check_comb();

    // Issue then writeback with bypass.
    step(1'b1, 5'd7, 1'b0, 5'd0, 5'd7, 5'd0);
    step(1'b0, 5'd0, 1'b0, 5'd0, 5'd7, 5'd0);
    chk("busy_a_pend7", 64'(busy_a_z), 64'd1);
    step(1'b0, 5'd0, 1'b0, 5'd0, 5'd7, 5'd0);
    step(1'b0, 5'd0, 1'b1, 5'd7, 5'd7, 5'd7);
    chk("we_r7", 64'(we_z), 64'h80);

    // WAW stall and same-cycle writeback/issue.
    step(1'b1, 5'd3, 1'b0, 5'd0, 5'd3, 5'd0);
    step(1'b1, 5'd3, 1'b0, 5'd0, 5'd3, 5'd0);
    step(1'b1, 5'd3, 1'b1, 5'd3, 5'd3, 5'd3);
    chk("we_r3", 64'(we_z), 64'h8);
    step(1'b0, 5'd0, 1'b1, 5'd3, 5'd0, 5'd0);

    // Zero register handling, both variants.
    step(1'b1, 5'd31, 1'b0, 5'd0, 5'd31, 5'd31);
    step(1'b0, 5'd0, 1'b1, 5'd31, 5'd31, 5'd0);
    chk("we_n_r31", 64'(we_n), 64'h80000000);

    // Spurious writeback.
    step(1'b0, 5'd0, 1'b1, 5'd12, 5'd12, 5'd0);
    chk("err_r12", 64'(err_z), 64'd1);
    step(1'b0, 5'd0, 1'b0, 5'd0, 5'd12, 5'd0);

    // Fill every trackable register.
    for (int i = 0; i < 31; i++) step(1'b1, 5'(i), 1'b0, 5'd0, 5'(i), 5'd0);
    chk("count_full", 64'(cnt_z), 64'd31);
    step(1'b1, 5'd5, 1'b0, 5'd0, 5'd5, 5'd30);
    step(1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 5'd6);
    step(1'b1, 5'd31, 1'b0, 5'd0, 5'd31, 5'd0);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    issue_valid = 1'b0; wb_valid = 1'b0; src_a = 5'd1; src_b = 5'd2;
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_pend_z", 64'(pend_z), 64'd0);
    chk("arst_cnt_z",  64'(cnt_z),  64'd0);
    chk("arst_pend_n", 64'(pend_n), 64'd0);
    chk("arst_cnt_n",  64'(cnt_n),  64'd0);
    check_regs();
    check_comb();
    @(negedge clk);
    reset_n = 1'b1;

    // Random traffic; register range narrowed at times to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] hi;
      hi = (n % 100 < 50) ? 5'd7 : 5'd31;
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, int'(hi))),
           1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, int'(hi))),
           5'($urandom_range(0, int'(hi))), 5'($urandom_range(0, 31)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
